writeback_cycle: RTL and testbench
==================================

Name: writeback_cycle

Overview:
Writeback stage; sits directly downstream of the memory stage and consumes its Mlatch outputs. It selects the writeback value and owns the 4x8 register file; R3 is the stack pointer. It also provides:
- read ports for decode, with write-through bypass;
- the RET program-counter redirect;
- the OUT port register;
- a retired-instruction counter.

Parameters:
DATA_W, 8, datapath width
SP_RESET, 8'hFF, reset value of R3 (stack pointer)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
reg_file_wenWB  in  2  bit0: write R[dest_addrWB]; bit1: write SP (R3)
dest_addrWB  in  2  destination register index
mux10_sWB  in  3  writeback source select
ALU_resultWB  in  8  ALU result
data_mem_outWB  in  8  data memory read value
sub_outWB  in  8  SP-1 from execute subtractor
instrWB  in  8  instruction or immediate byte
sp_mux_sWB  in  1  SP write source: 0 = sub_outWB, 1 = SP+1
RET_enWB  in  1  return: load PC from data_mem_outWB
in_port  in  8  external input port
rd_addr1  in  2  read port 1 address
rd_addr2  in  2  read port 2 address
data_out1  out  8  R[rd_addr1], with bypass
data_out2  out  8  R[rd_addr2], with bypass
sp_out  out  8  current R3, with bypass
wb_data  out  8  selected writeback value (forwarding)
wb_dest  out  2  dest_addrWB passthrough
wb_valid  out  1  reg_file_wenWB[0]
pc_load_en  out  1  PC redirect strobe
pc_load_val  out  8  PC redirect target
out_port  out  8  OUT port register
out_port_valid  out  1  one-cycle pulse after each OUT update
retired_cnt  out  16  retired-instruction count

Behaviour:
Clock and reset:
- One clock, clk.
- rst is asynchronous and active-high.

Reset values:
- R0..R2 = 0; R3 = SP_RESET.
- out_port = 0; out_port_valid = 0; retired_cnt = 0.
- Combinational outputs follow the reset register state.

wb_data select (mux10_sWB), combinational:
- 0: ALU_resultWB
- 1: data_mem_outWB
- 2: in_port
- 3: instrWB
- 4: sub_outWB
- 5: R[dest_addrWB] (OUT)
- 6, 7: 0

Register writes, on rising clk:
- Dest write: if reg_file_wenWB[0], R[dest_addrWB] <= wb_data.
- SP write: if reg_file_wenWB[1], R3 <= sp_mux_sWB ? R3+1 : sub_outWB.
- SP increment is mod 256: 8'hFF+1 = 8'h00; no flag.
- Conflict: both enables set and dest_addrWB==3 -> SP write wins; the dest write is dropped.

Read ports, combinational (write-through bypass):
- data_out1, data_out2 and sp_out return the value being written this cycle when their address matches an active write (the same value the register file will hold next cycle).
- With both enables set and dest_addrWB==3, the R3 bypass value follows the SP-port rule.
- A dest write to R0..R2 never affects sp_out.

RET redirect:
- pc_load_en = RET_enWB; pc_load_val = data_mem_outWB; combinational, same cycle.
- Register writes during RET are processed normally (SP pop).

OUT port:
- When mux10_sWB==5, out_port <= R[dest_addrWB] (pre-write value) on the clock edge.
- out_port_valid is registered high for exactly the following cycle.
- Back-to-back OUTs keep out_port_valid high continuously.

retired_cnt:
- Increments by 1 on each edge where reg_file_wenWB!=0, or RET_enWB, or mux10_sWB==5; at most +1 per cycle.
- Wraps from 16'hFFFF to 0.

Reset mid-operation:
- Asserting rst overrides any write in that cycle.
- On rst deassertion, the first edge processes inputs normally.

Latency:
- Register write visible on ports in the same cycle via bypass; from register storage on the next cycle.
- out_port: 1 cycle.

Test Plan:
1. Reset -> R0..R2=0, sp_out=FF, out_port=0, retired_cnt=0; assert rst mid-write of R1=55 -> R1 stays 0.
2. wen=01, dest=2, mux10=0, ALU=3C, rd_addr1=2 -> data_out1=3C in the same cycle; R2=3C after the edge; retired_cnt=1.
3. PUSH: wen=10, sp_mux=0, sub_out=FE -> sp_out=FE. POP from SP=FF: sp_mux=1 -> SP=00 (wrap).
4. Conflict: wen=11, dest=3, mux10=0, ALU=77, sp_mux=0, sub_out=FE -> R3=FE (SP wins); sp_out shows FE in the same cycle.
5. RET_en=1, data_mem_out=A4 -> pc_load_en=1 and pc_load_val=A4 in the same cycle; with wen=10, sp_mux=1 and SP=FE -> SP=FF.
6. R1=9B; mux10=5, dest=1 for two cycles -> out_port=9B, out_port_valid high for two cycles then low; retired_cnt +2. mux10=2, in_port=5A, wen=01, dest=0 -> R0=5A.

Source files
------------

// File: rtl/writeback_cycle.sv
// Writeback stage: selects the writeback value, owns the 4x8 register file (R3 = SP),
// and provides bypassed read ports, the RET PC redirect, the OUT port and a retired counter.
module writeback_cycle #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] SP_RESET = 8'hFF,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        reg_file_wenWB,
    input  logic [1:0]        dest_addrWB,
    input  logic [2:0]        mux10_sWB,
    input  logic [DATA_W-1:0] ALU_resultWB,
    input  logic [DATA_W-1:0] data_mem_outWB,
    input  logic [DATA_W-1:0] sub_outWB,
    input  logic [DATA_W-1:0] instrWB,
    input  logic              sp_mux_sWB,
    input  logic              RET_enWB,
    input  logic [DATA_W-1:0] in_port,
    input  logic [1:0]        rd_addr1,
    input  logic [1:0]        rd_addr2,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] sp_out,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        wb_dest,
    output logic              wb_valid,
    output logic              pc_load_en,
    output logic [DATA_W-1:0] pc_load_val,
    output logic [DATA_W-1:0] out_port,
    output logic              out_port_valid,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic [DATA_W-1:0] rf [4];
    logic [DATA_W-1:0] sp_next;
    logic              sp_we;
    logic              dest_we;
    logic              out_sel;
    logic              retire;

    assign out_sel = (mux10_sWB == 3'd5);
    assign sp_we   = reg_file_wenWB[1];
    // SP port wins when both writes target R3
    assign dest_we = reg_file_wenWB[0] && !(sp_we && dest_addrWB == 2'd3);
    assign sp_next = sp_mux_sWB ? rf[3] + {{(DATA_W-1){1'b0}}, 1'b1} : sub_outWB;
    assign retire  = (reg_file_wenWB != 2'b00) || RET_enWB || out_sel;

    always_comb begin
        wb_data = '0;
        case (mux10_sWB)
            3'd0:    wb_data = ALU_resultWB;
            3'd1:    wb_data = data_mem_outWB;
            3'd2:    wb_data = in_port;
            3'd3:    wb_data = instrWB;
            3'd4:    wb_data = sub_outWB;
            3'd5:    wb_data = rf[dest_addrWB];
            default: wb_data = '0;
        endcase
    end

    // Returns the value the register will hold after this edge
    function automatic logic [DATA_W-1:0] rd_port(input logic [1:0] addr);
        if (sp_we && addr == 2'd3)
            return sp_next;
        else if (dest_we && addr == dest_addrWB)
            return wb_data;
        else
            return rf[addr];
    endfunction

    always_comb begin
        data_out1 = rd_port(rd_addr1);
        data_out2 = rd_port(rd_addr2);
        sp_out    = rd_port(2'd3);
    end

    assign wb_dest     = dest_addrWB;
    assign wb_valid    = reg_file_wenWB[0];
    assign pc_load_en  = RET_enWB;
    assign pc_load_val = data_mem_outWB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf[0] <= '0;
            rf[1] <= '0;
            rf[2] <= '0;
            rf[3] <= SP_RESET;
        end else begin
            if (dest_we)
                rf[dest_addrWB] <= wb_data;
            if (sp_we)
                rf[3] <= sp_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_port       <= '0;
            out_port_valid <= 1'b0;
            retired_cnt    <= '0;
        end else begin
            out_port_valid <= out_sel;
            if (out_sel)
                out_port <= rf[dest_addrWB];
            if (retire)
                retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_writeback_cycle.sv
// Bench for writeback_cycle: table of vectors with combinational checks plus a
// scoreboard queue for the registered outputs, followed by reset and wrap sequences.
module tb_writeback_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reg_file_wenWB, dest_addrWB, rd_addr1, rd_addr2, wb_dest;
    logic [2:0]  mux10_sWB;
    logic [7:0]  ALU_resultWB, data_mem_outWB, sub_outWB, instrWB, in_port;
    logic        sp_mux_sWB, RET_enWB;
    logic [7:0]  data_out1, data_out2, sp_out, wb_data, pc_load_val, out_port;
    logic        wb_valid, pc_load_en, out_port_valid;
    logic [15:0] retired_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    writeback_cycle dut (
        .clk(clk), .rst(rst),
        .reg_file_wenWB(reg_file_wenWB), .dest_addrWB(dest_addrWB), .mux10_sWB(mux10_sWB),
        .ALU_resultWB(ALU_resultWB), .data_mem_outWB(data_mem_outWB), .sub_outWB(sub_outWB),
        .instrWB(instrWB), .sp_mux_sWB(sp_mux_sWB), .RET_enWB(RET_enWB), .in_port(in_port),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .data_out1(data_out1), .data_out2(data_out2), .sp_out(sp_out), .wb_data(wb_data),
        .wb_dest(wb_dest), .wb_valid(wb_valid), .pc_load_en(pc_load_en), .pc_load_val(pc_load_val),
        .out_port(out_port), .out_port_valid(out_port_valid), .retired_cnt(retired_cnt)
    );

    typedef struct {
        logic [1:0] wen, dest;
        logic [2:0] mux;
        logic [7:0] alu, dmem, sub, instr;
        logic       spm, ret;
        logic [7:0] inp;
        logic [1:0] ra1, ra2;
        logic [7:0] e_do1, e_do2, e_sp, e_wb;
        logic       e_pce;
        logic [7:0] e_pcv;
        logic [7:0] e_out;
        logic       e_ov;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [7:0]  out;
        logic        ov;
        logic [15:0] cnt;
    } reg_exp_t;

    reg_exp_t sb_q[$];
    vec_t     tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic [1:0] wen, input logic [1:0] dest, input logic [2:0] mux,
        input logic [7:0] alu, input logic [7:0] dmem, input logic [7:0] sub, input logic [7:0] instr,
        input logic spm, input logic ret, input logic [7:0] inp,
        input logic [1:0] ra1, input logic [1:0] ra2,
        input logic [7:0] e_do1, input logic [7:0] e_do2, input logic [7:0] e_sp, input logic [7:0] e_wb,
        input logic e_pce, input logic [7:0] e_pcv,
        input logic [7:0] e_out, input logic e_ov, input logic [15:0] e_cnt);
        vec_t v;
        v.wen = wen; v.dest = dest; v.mux = mux; v.alu = alu; v.dmem = dmem; v.sub = sub;
        v.instr = instr; v.spm = spm; v.ret = ret; v.inp = inp; v.ra1 = ra1; v.ra2 = ra2;
        v.e_do1 = e_do1; v.e_do2 = e_do2; v.e_sp = e_sp; v.e_wb = e_wb;
        v.e_pce = e_pce; v.e_pcv = e_pcv; v.e_out = e_out; v.e_ov = e_ov; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive_idle();
        reg_file_wenWB = 2'b00; dest_addrWB = 2'd0; mux10_sWB = 3'd0;
        ALU_resultWB = 8'h00; data_mem_outWB = 8'h00; sub_outWB = 8'h00; instrWB = 8'h00;
        sp_mux_sWB = 1'b0; RET_enWB = 1'b0; in_port = 8'h00; rd_addr1 = 2'd0; rd_addr2 = 2'd0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        reg_exp_t e, got;
        reg_file_wenWB = v.wen; dest_addrWB = v.dest; mux10_sWB = v.mux;
        ALU_resultWB = v.alu; data_mem_outWB = v.dmem; sub_outWB = v.sub; instrWB = v.instr;
        sp_mux_sWB = v.spm; RET_enWB = v.ret; in_port = v.inp; rd_addr1 = v.ra1; rd_addr2 = v.ra2;
        #1;
        chk($sformatf("v%0d data_out1", idx), {8'h00, data_out1}, {8'h00, v.e_do1});
        chk($sformatf("v%0d data_out2", idx), {8'h00, data_out2}, {8'h00, v.e_do2});
        chk($sformatf("v%0d sp_out", idx), {8'h00, sp_out}, {8'h00, v.e_sp});
        chk($sformatf("v%0d wb_data", idx), {8'h00, wb_data}, {8'h00, v.e_wb});
        chk($sformatf("v%0d pc_load_en", idx), {15'h0, pc_load_en}, {15'h0, v.e_pce});
        chk($sformatf("v%0d pc_load_val", idx), {8'h00, pc_load_val}, {8'h00, v.e_pcv});
        if (idx == 0) begin
            chk("wb_dest", {14'h0, wb_dest}, {14'h0, v.dest});
            chk("wb_valid", {15'h0, wb_valid}, {15'h0, v.wen[0]});
        end
        e.out = v.e_out; e.ov = v.e_ov; e.cnt = v.e_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk($sformatf("v%0d out_port", idx), {8'h00, out_port}, {8'h00, got.out});
        chk($sformatf("v%0d out_port_valid", idx), {15'h0, out_port_valid}, {15'h0, got.ov});
        chk($sformatf("v%0d retired_cnt", idx), retired_cnt, got.cnt);
    endtask

    initial begin
        // wen dest mux alu dmem sub instr spm ret inp ra1 ra2 | do1 do2 sp wb pce pcv | out ov cnt
        tbl.push_back(mk(2'd0,2'd0,3'd0,8'h00,8'h00,8'h00,8'h00,0,0,8'h00,2'd0,2'd3, 8'h00,8'hFF,8'hFF,8'h00,0,8'h00, 8'h00,0,16'd0));
        tbl.push_back(mk(2'd1,2'd2,3'd0,8'h3C,8'h00,8'h00,8'h00,0,0,8'h00,2'd2,2'd1, 8'h3C,8'h00,8'hFF,8'h3C,0,8'h00, 8'h00,0,16'd1));
        tbl.push_back(mk(2'd0,2'd0,3'd0,8'h00,8'h00,8'h00,8'h00,0,0,8'h00,2'd2,2'd0, 8'h3C,8'h00,8'hFF,8'h00,0,8'h00, 8'h00,0,16'd1));
        tbl.push_back(mk(2'd2,2'd0,3'd0,8'h00,8'h00,8'hFE,8'h00,0,0,8'h00,2'd3,2'd2, 8'hFE,8'h3C,8'hFE,8'h00,0,8'h00, 8'h00,0,16'd2));
        tbl.push_back(mk(2'd2,2'd0,3'd0,8'h00,8'h00,8'h00,8'h00,1,0,8'h00,2'd3,2'd3, 8'hFF,8'hFF,8'hFF,8'h00,0,8'h00, 8'h00,0,16'd3));
        tbl.push_back(mk(2'd2,2'd0,3'd0,8'h00,8'h00,8'h00,8'h00,1,0,8'h00,2'd3,2'd2, 8'h00,8'h3C,8'h00,8'h00,0,8'h00, 8'h00,0,16'd4));
        tbl.push_back(mk(2'd3,2'd3,3'd0,8'h77,8'h00,8'hFE,8'h00,0,0,8'h00,2'd3,2'd0, 8'hFE,8'h00,8'hFE,8'h77,0,8'h00, 8'h00,0,16'd5));
        tbl.push_back(mk(2'd2,2'd0,3'd0,8'h00,8'hA4,8'h00,8'h00,1,1,8'h00,2'd3,2'd1, 8'hFF,8'h00,8'hFF,8'h00,1,8'hA4, 8'h00,0,16'd6));
        tbl.push_back(mk(2'd0,2'd0,3'd0,8'h00,8'h10,8'h00,8'h00,0,1,8'h00,2'd0,2'd2, 8'h00,8'h3C,8'hFF,8'h00,1,8'h10, 8'h00,0,16'd7));
        tbl.push_back(mk(2'd1,2'd1,3'd3,8'h00,8'h00,8'h00,8'h9B,0,0,8'h00,2'd1,2'd3, 8'h9B,8'hFF,8'hFF,8'h9B,0,8'h00, 8'h00,0,16'd8));
        tbl.push_back(mk(2'd0,2'd1,3'd5,8'h00,8'h00,8'h00,8'h00,0,0,8'h00,2'd1,2'd2, 8'h9B,8'h3C,8'hFF,8'h9B,0,8'h00, 8'h9B,1,16'd9));
        tbl.push_back(mk(2'd0,2'd1,3'd5,8'h00,8'h00,8'h00,8'h00,0,0,8'h00,2'd1,2'd2, 8'h9B,8'h3C,8'hFF,8'h9B,0,8'h00, 8'h9B,1,16'd10));
        tbl.push_back(mk(2'd0,2'd0,3'd0,8'h00,8'h00,8'h00,8'h00,0,0,8'h00,2'd1,2'd0, 8'h9B,8'h00,8'hFF,8'h00,0,8'h00, 8'h9B,0,16'd10));
        tbl.push_back(mk(2'd1,2'd0,3'd2,8'h00,8'h00,8'h00,8'h00,0,0,8'h5A,2'd0,2'd1, 8'h5A,8'h9B,8'hFF,8'h5A,0,8'h00, 8'h9B,0,16'd11));
        tbl.push_back(mk(2'd1,2'd3,3'd4,8'h00,8'h00,8'h33,8'h00,0,0,8'h00,2'd3,2'd0, 8'h33,8'h5A,8'h33,8'h33,0,8'h00, 8'h9B,0,16'd12));
        tbl.push_back(mk(2'd3,2'd2,3'd1,8'h00,8'hC7,8'h00,8'h00,1,0,8'h00,2'd2,2'd3, 8'hC7,8'h34,8'h34,8'hC7,0,8'hC7, 8'h9B,0,16'd13));
        tbl.push_back(mk(2'd1,2'd0,3'd6,8'hAA,8'h00,8'h00,8'h00,0,0,8'h00,2'd0,2'd1, 8'h00,8'h9B,8'h34,8'h00,0,8'h00, 8'h9B,0,16'd14));
        tbl.push_back(mk(2'd1,2'd2,3'd5,8'h00,8'h00,8'h00,8'h00,0,0,8'h00,2'd2,2'd3, 8'hC7,8'h34,8'h34,8'hC7,0,8'h00, 8'hC7,1,16'd15));
        tbl.push_back(mk(2'd0,2'd0,3'd0,8'h00,8'h00,8'h00,8'h00,0,0,8'h00,2'd0,2'd2, 8'h00,8'hC7,8'h34,8'h00,0,8'h00, 8'hC7,0,16'd15));

        // Reset, with a write to R1 attempted while rst is held
        rst = 1'b1;
        drive_idle();
        reg_file_wenWB = 2'b01; dest_addrWB = 2'd1; ALU_resultWB = 8'h55;
        @(posedge clk); @(posedge clk); #1;
        drive_idle();
        rd_addr1 = 2'd1; rd_addr2 = 2'd2;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst R1", {8'h00, data_out1}, 16'h0000);
        chk("rst R2", {8'h00, data_out2}, 16'h0000);
        chk("rst sp_out", {8'h00, sp_out}, 16'h00FF);
        chk("rst out_port", {8'h00, out_port}, 16'h0000);
        chk("rst out_port_valid", {15'h0, out_port_valid}, 16'h0000);
        chk("rst retired_cnt", retired_cnt, 16'h0000);

        foreach (tbl[i]) apply(tbl[i], i);

        // Asynchronous reset asserted mid-write, between edges
        reg_file_wenWB = 2'b11; dest_addrWB = 2'd1; ALU_resultWB = 8'h55;
        sp_mux_sWB = 1'b0; sub_outWB = 8'h20; mux10_sWB = 3'd0; rd_addr2 = 2'd2;
        #1;
        rst = 1'b1;
        #1;
        chk("async rst retired_cnt", retired_cnt, 16'h0000);
        chk("async rst out_port", {8'h00, out_port}, 16'h0000);
        chk("async rst R2", {8'h00, data_out2}, 16'h0000);
        @(posedge clk); #1;
        drive_idle();
        rd_addr1 = 2'd1; rd_addr2 = 2'd3;
        rst = 1'b0;
        #1;
        chk("post rst R1", {8'h00, data_out1}, 16'h0000);
        chk("post rst sp_out", {8'h00, sp_out}, 16'h00FF);
        chk("post rst retired_cnt", retired_cnt, 16'h0000);
        apply(mk(2'd1,2'd1,3'd0,8'h66,8'h00,8'h00,8'h00,0,0,8'h00,2'd1,2'd3, 8'h66,8'hFF,8'hFF,8'h66,0,8'h00, 8'h00,0,16'd1), 100);

        // Counter wrap: retire via RET only, no register writes
        drive_idle();
        RET_enWB = 1'b1;
        for (int k = 0; k < 65534; k++) @(posedge clk);
        #1;
        chk("cnt at max", retired_cnt, 16'hFFFF);
        @(posedge clk); #1;
        chk("cnt wrap", retired_cnt, 16'h0000);
        RET_enWB = 1'b0;
        @(posedge clk); #1;
        chk("cnt hold", retired_cnt, 16'h0000);
        rd_addr1 = 2'd1;
        #1;
        chk("R1 after wrap run", {8'h00, data_out1}, 16'h0066);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
